// File: rtl/kernel_cf_pio.sv
// CompactFlash PIO bridge: debounced card detect, control registers, and a timed IDE strobe FSM; ctl readdata one cycle late.
// IDE slave holds av_ide_waitrequest from accept through the last PULSE cycle; define KERNEL_CF_IORDY_EN to honour iordy with timeout.
module kernel_cf_pio #(
    parameter int DATA_WIDTH      = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SETUP_DEF       = 2,
    parameter int PULSE_DEF       = 6,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  av_reset,
    input  logic [1:0]            av_ctl_address,
    input  logic                  av_ctl_chipselect_n,
    input  logic                  av_ctl_read_n,
    input  logic                  av_ctl_write_n,
    input  logic [7:0]            av_ctl_writedata,
    output logic [7:0]            av_ctl_readdata,
    output logic                  av_ctl_irq,
    input  logic [3:0]            av_ide_address,
    input  logic                  av_ide_chipselect_n,
    input  logic                  av_ide_read_n,
    input  logic                  av_ide_write_n,
    input  logic [DATA_WIDTH-1:0] av_ide_writedata,
    output logic [DATA_WIDTH-1:0] av_ide_readdata,
    output logic                  av_ide_waitrequest,
    output logic                  av_ide_irq,
    input  logic                  detect_n,
    input  logic                  intrq,
    input  logic                  iordy,
    output logic [10:0]           addr,
    output logic [1:0]            cs_n,
    output logic                  iord_n,
    output logic                  iowr_n,
    inout  wire  [DATA_WIDTH-1:0] data_cf,
    output logic                  power,
    output logic                  reset_n_cf,
    output logic                  atasel_n,
    output logic                  we_n,
    output logic                  rfu
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, RECOVER} state_t;

    state_t                state_q, state_d;
    logic                  present_q, present_d, present_d1_q;
    logic [DW-1:0]         dcnt_q, dcnt_d;
    logic                  irq_q, irq_d;
    logic                  irq_en_q, irq_en_d;
    logic                  reset_reg_q, reset_reg_d;
    logic                  power_reg_q, power_reg_d;
    logic                  ide_irq_en_q, ide_irq_en_d;
    logic [3:0]            setup_q, setup_d;
    logic [3:0]            pulse_q, pulse_d;
    logic                  timeout_q, timeout_d;
    logic                  timeout_set;
    logic [7:0]            ctl_rdata_q, ctl_rdata_d;
    logic [3:0]            addr_q, addr_d;
    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [3:0]            tcnt_q, tcnt_d;
    logic [3:0]            plat_q, plat_d;

    logic ctl_wr, ctl_rd, ide_req, xfer, strobe;

`ifdef KERNEL_CF_IORDY_EN
    localparam int PW = $clog2(TIMEOUT_CYCLES + 1);
    logic [PW-1:0] ptot_q, ptot_d;
`else
    localparam logic [31:0] TO_L = TIMEOUT_CYCLES;
    logic unused_ok;
    assign unused_ok = &{1'b0, iordy, TO_L[0]};
`endif

    assign ctl_wr  = !av_ctl_chipselect_n && !av_ctl_write_n;
    assign ctl_rd  = !av_ctl_chipselect_n && !av_ctl_read_n;
    assign ide_req = !av_ide_chipselect_n && (!av_ide_read_n || !av_ide_write_n);

    // Card detect debounce and control register file.
    always_comb begin
        present_d    = present_q;
        dcnt_d       = dcnt_q;
        irq_d        = irq_q;
        irq_en_d     = irq_en_q;
        reset_reg_d  = reset_reg_q;
        power_reg_d  = power_reg_q;
        ide_irq_en_d = ide_irq_en_q;
        setup_d      = setup_q;
        pulse_d      = pulse_q;
        timeout_d    = timeout_q;
        ctl_rdata_d  = 8'h00;

        if (detect_n) begin
            present_d = 1'b0;
            dcnt_d    = '0;
        end else if (!present_q) begin
            if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                present_d = 1'b1;
                dcnt_d    = DW'(DEBOUNCE_CYCLES);
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end

        if ((present_q != present_d1_q) && irq_en_q)
            irq_d = 1'b1;
        if (ctl_rd && (av_ctl_address == 2'd0))
            irq_d = 1'b0;

        if (ctl_wr) begin
            case (av_ctl_address)
                2'd0: {irq_en_d, reset_reg_d, power_reg_d} = av_ctl_writedata[3:1];
                2'd1: ide_irq_en_d = av_ctl_writedata[0];
                2'd2: begin
                    setup_d = (av_ctl_writedata[3:0] == 4'd0) ? 4'd1 : av_ctl_writedata[3:0];
                    pulse_d = (av_ctl_writedata[7:4] == 4'd0) ? 4'd1 : av_ctl_writedata[7:4];
                end
                2'd3: if (av_ctl_writedata[0]) timeout_d = 1'b0;
            endcase
        end
        if (timeout_set)
            timeout_d = 1'b1;

        case (av_ctl_address)
            2'd0: ctl_rdata_d = {4'b0, irq_en_q, reset_reg_q, power_reg_q, present_q};
            2'd1: ctl_rdata_d = {7'b0, ide_irq_en_q};
            2'd2: ctl_rdata_d = {pulse_q, setup_q};
            2'd3: ctl_rdata_d = {7'b0, timeout_q};
        endcase
    end

    // Transfer FSM; timing fields are snapshotted at accept so mid-transfer writes wait for the next one.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        tcnt_d      = tcnt_q;
        plat_d      = plat_q;
        timeout_set = 1'b0;
`ifdef KERNEL_CF_IORDY_EN
        ptot_d      = ptot_q;
`endif
        case (state_q)
            IDLE: begin
                if (ide_req && present_q) begin
                    state_d = SETUP;
                    addr_d  = av_ide_address;
                    wr_d    = !av_ide_write_n;
                    wdata_d = av_ide_writedata;
                    tcnt_d  = setup_q;
                    plat_d  = pulse_q;
                end
            end
            SETUP: begin
                if (!present_q) begin
                    state_d = RECOVER;
                    rdata_d = '1;
                end else if (tcnt_q <= 4'd1) begin
                    state_d = PULSE;
                    tcnt_d  = plat_q;
`ifdef KERNEL_CF_IORDY_EN
                    ptot_d  = '0;
`endif
                end else begin
                    tcnt_d = tcnt_q - 4'd1;
                end
            end
            PULSE: begin
                if (!present_q) begin
                    state_d = RECOVER;
                    rdata_d = '1;
`ifdef KERNEL_CF_IORDY_EN
                end else if ((tcnt_q <= 4'd1) && iordy) begin
                    state_d = RECOVER;
                    rdata_d = data_cf;
                end else if (ptot_q == PW'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = RECOVER;
                    rdata_d     = '1;
                    timeout_set = 1'b1;
                end else begin
                    if (tcnt_q > 4'd1)
                        tcnt_d = tcnt_q - 4'd1;
                    ptot_d = ptot_q + PW'(1);
                end
`else
                end else if (tcnt_q <= 4'd1) begin
                    state_d = RECOVER;
                    rdata_d = data_cf;
                end else begin
                    tcnt_d = tcnt_q - 4'd1;
                end
`endif
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge av_reset) begin
        if (av_reset) begin
            state_q      <= IDLE;
            present_q    <= 1'b0;
            present_d1_q <= 1'b0;
            dcnt_q       <= '0;
            irq_q        <= 1'b0;
            irq_en_q     <= 1'b0;
            reset_reg_q  <= 1'b0;
            power_reg_q  <= 1'b0;
            ide_irq_en_q <= 1'b0;
            setup_q      <= 4'(SETUP_DEF);
            pulse_q      <= 4'(PULSE_DEF);
            timeout_q    <= 1'b0;
            ctl_rdata_q  <= 8'h00;
            addr_q       <= 4'd0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            tcnt_q       <= 4'd0;
            plat_q       <= 4'd0;
`ifdef KERNEL_CF_IORDY_EN
            ptot_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            present_q    <= present_d;
            present_d1_q <= present_q;
            dcnt_q       <= dcnt_d;
            irq_q        <= irq_d;
            irq_en_q     <= irq_en_d;
            reset_reg_q  <= reset_reg_d;
            power_reg_q  <= power_reg_d;
            ide_irq_en_q <= ide_irq_en_d;
            setup_q      <= setup_d;
            pulse_q      <= pulse_d;
            timeout_q    <= timeout_d;
            ctl_rdata_q  <= ctl_rdata_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            tcnt_q       <= tcnt_d;
            plat_q       <= plat_d;
`ifdef KERNEL_CF_IORDY_EN
            ptot_q       <= ptot_d;
`endif
        end
    end

    // Gating with present_q drops bus activity as soon as the card is reported gone.
    assign xfer   = ((state_q == SETUP) || (state_q == PULSE)) && present_q;
    assign strobe = (state_q == PULSE) && present_q;

    assign iord_n  = !(strobe && !wr_q);
    assign iowr_n  = !(strobe && wr_q);
    assign cs_n    = {!(xfer && addr_q[3]), !(xfer && !addr_q[3])};
    assign addr    = {8'b0, addr_q[2:0]};
    assign data_cf = (xfer && wr_q) ? wdata_q : 'z;

    assign av_ide_waitrequest = ((state_q == IDLE) && ide_req && present_q) ||
                                (state_q == SETUP) || (state_q == PULSE);
    assign av_ide_readdata    = (state_q == RECOVER) ? rdata_q : '1;
    assign av_ide_irq         = intrq && ide_irq_en_q && present_q;

    assign av_ctl_readdata = ctl_rdata_q;
    assign av_ctl_irq      = irq_q;

    assign power      = power_reg_q && present_q;
    assign reset_n_cf = !(reset_reg_q || av_reset || !present_q);
    assign atasel_n   = 1'b0;
    assign we_n       = 1'b1;
    assign rfu        = 1'b1;

endmodule

// File: tb/tb_kernel_cf_pio.sv
// Directed bench for kernel_cf_pio: reset, debounce/irq, timed PIO reads/writes, removal, reset abort, iordy.
module tb_kernel_cf_pio;

    localparam int DEB = 16;

    logic        clk = 1'b0;
    logic        av_reset;
    logic [1:0]  av_ctl_address;
    logic        av_ctl_chipselect_n, av_ctl_read_n, av_ctl_write_n;
    logic [7:0]  av_ctl_writedata, av_ctl_readdata;
    logic        av_ctl_irq;
    logic [3:0]  av_ide_address;
    logic        av_ide_chipselect_n, av_ide_read_n, av_ide_write_n;
    logic [15:0] av_ide_writedata, av_ide_readdata;
    logic        av_ide_waitrequest, av_ide_irq;
    logic        detect_n, intrq, iordy;
    logic [10:0] addr;
    logic [1:0]  cs_n;
    logic        iord_n, iowr_n;
    wire  [15:0] data_cf;
    logic        power, reset_n_cf, atasel_n, we_n, rfu;

    logic        tb_drv;
    logic [15:0] tb_dat;
    assign data_cf = tb_drv ? tb_dat : 16'hzzzz;

    int n_chk = 0;
    int n_err = 0;

    logic [1:0]  cap_cs;
    logic [10:0] cap_addr;
    logic [15:0] cap_dat;

    always #5 clk = ~clk;

    kernel_cf_pio #(.DATA_WIDTH(16), .DEBOUNCE_CYCLES(DEB), .SETUP_DEF(2),
                    .PULSE_DEF(6), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .av_reset(av_reset),
        .av_ctl_address(av_ctl_address), .av_ctl_chipselect_n(av_ctl_chipselect_n),
        .av_ctl_read_n(av_ctl_read_n), .av_ctl_write_n(av_ctl_write_n),
        .av_ctl_writedata(av_ctl_writedata), .av_ctl_readdata(av_ctl_readdata),
        .av_ctl_irq(av_ctl_irq),
        .av_ide_address(av_ide_address), .av_ide_chipselect_n(av_ide_chipselect_n),
        .av_ide_read_n(av_ide_read_n), .av_ide_write_n(av_ide_write_n),
        .av_ide_writedata(av_ide_writedata), .av_ide_readdata(av_ide_readdata),
        .av_ide_waitrequest(av_ide_waitrequest), .av_ide_irq(av_ide_irq),
        .detect_n(detect_n), .intrq(intrq), .iordy(iordy),
        .addr(addr), .cs_n(cs_n), .iord_n(iord_n), .iowr_n(iowr_n),
        .data_cf(data_cf), .power(power), .reset_n_cf(reset_n_cf),
        .atasel_n(atasel_n), .we_n(we_n), .rfu(rfu)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ctl_write(input logic [1:0] a, input logic [7:0] d);
        av_ctl_address = a; av_ctl_writedata = d;
        av_ctl_chipselect_n = 1'b0; av_ctl_write_n = 1'b0;
        tick;
        av_ctl_chipselect_n = 1'b1; av_ctl_write_n = 1'b1;
    endtask

    task automatic ctl_read(input logic [1:0] a, output logic [7:0] d);
        av_ctl_address = a;
        av_ctl_chipselect_n = 1'b0; av_ctl_read_n = 1'b0;
        tick;
        d = av_ctl_readdata;
        av_ctl_chipselect_n = 1'b1; av_ctl_read_n = 1'b1;
    endtask

    // wcyc: cycles with waitrequest high; scyc: selected strobe low; pcyc: waited cycles before strobe; xcyc: wrong strobe low.
    task automatic ide_xfer(input logic wr, input logic [3:0] a, input logic [15:0] wd,
                            output logic [15:0] rd, output int wcyc, output int scyc,
                            output int pcyc, output int xcyc);
        logic done, seen;
        done = 1'b0; seen = 1'b0; rd = 16'h0;
        wcyc = 0; scyc = 0; pcyc = 0; xcyc = 0;
        av_ide_address = a; av_ide_writedata = wd; av_ide_chipselect_n = 1'b0;
        if (wr) av_ide_write_n = 1'b0; else av_ide_read_n = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!av_ide_waitrequest) begin
                rd = av_ide_readdata;
                done = 1'b1;
                break;
            end
            wcyc++;
            if ((wr ? iowr_n : iord_n) == 1'b0) begin
                if (!seen) begin
                    seen = 1'b1; pcyc = wcyc - 1;
                    cap_cs = cs_n; cap_addr = addr; cap_dat = data_cf;
                end
                scyc++;
            end
            if ((wr ? iord_n : iowr_n) == 1'b0) xcyc++;
        end
        check("xfer_done", {31'b0, done}, 32'd1);
        @(posedge clk); #1;
        av_ide_chipselect_n = 1'b1; av_ide_read_n = 1'b1; av_ide_write_n = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  d;
        logic [15:0] rd;
        int w, s, p, x;

        av_reset = 1'b1;
        av_ctl_address = 2'd0; av_ctl_chipselect_n = 1'b1; av_ctl_read_n = 1'b1;
        av_ctl_write_n = 1'b1; av_ctl_writedata = 8'h0;
        av_ide_address = 4'd0; av_ide_chipselect_n = 1'b1; av_ide_read_n = 1'b1;
        av_ide_write_n = 1'b1; av_ide_writedata = 16'h0;
        detect_n = 1'b1; intrq = 1'b0; iordy = 1'b1; tb_drv = 1'b0; tb_dat = 16'h0;
        repeat (3) @(posedge clk);
        #1;

        check("rst_iord_n", iord_n, 1);
        check("rst_iowr_n", iowr_n, 1);
        check("rst_cs_n", cs_n, 2'b11);
        check("rst_waitreq", av_ide_waitrequest, 0);
        check("rst_ctl_rdata", av_ctl_readdata, 0);
        check("rst_ctl_irq", av_ctl_irq, 0);
        check("rst_power", power, 0);
        check("rst_reset_n_cf", reset_n_cf, 0);
        check("const_pins", {atasel_n, we_n, rfu}, 3'b011);
        av_reset = 1'b0;
        tick;
        ctl_read(2'd2, d);  check("rst_timing", d, 8'h62);

        // Debounce and insert interrupt
        ctl_write(2'd0, 8'h0A);
        detect_n = 1'b0;
        repeat (DEB - 1) tick;
        check("debounce_pre", power, 0);
        tick;
        check("debounce_set", power, 1);
        check("irq_lag", av_ctl_irq, 0);
        tick;
        check("irq_set", av_ctl_irq, 1);
        check("reset_n_cf_on", reset_n_cf, 1);
        ctl_read(2'd0, d);  check("ctl0_rd", d, 8'h0B);
        check("irq_clr", av_ctl_irq, 0);

        // Default-timing read at address 3
        tb_drv = 1'b1; tb_dat = 16'hBEEF;
        ide_xfer(1'b0, 4'd3, 16'h0, rd, w, s, p, x);
        check("rd_data", rd, 16'hBEEF);
        check("rd_wait", w, 9);
        check("rd_pulse", s, 6);
        check("rd_setup", p, 3);
        check("rd_no_iowr", x, 0);
        check("rd_cs_n", cap_cs, 2'b10);
        check("rd_addr", cap_addr, 11'd3);
        tb_drv = 1'b0;

        // Timing register and write transfer
        ctl_write(2'd2, 8'h00);
        ctl_read(2'd2, d);  check("timing_zero", d, 8'h11);
        ctl_write(2'd2, 8'h31);
        ide_xfer(1'b1, 4'd0, 16'h5A1B, rd, w, s, p, x);
        check("wr_pulse", s, 3);
        check("wr_setup", p, 2);
        check("wr_wait", w, 5);
        check("wr_data", cap_dat, 16'h5A1B);
        check("wr_cs_n", cap_cs, 2'b10);
        check("wr_no_iord", x, 0);

        // Timing change mid-transfer only affects the next transfer
        tb_drv = 1'b1; tb_dat = 16'h1234;
        fork
            ide_xfer(1'b0, 4'hA, 16'h0, rd, w, s, p, x);
            begin repeat (2) tick; ctl_write(2'd2, 8'h62); end
        join
        check("mid_pulse_old", s, 3);
        check("mid_data", rd, 16'h1234);
        check("mid_cs_n", cap_cs, 2'b01);
        check("mid_addr", cap_addr, 11'd2);
        ide_xfer(1'b0, 4'd1, 16'h0, rd, w, s, p, x);
        check("next_pulse_new", s, 6);
        check("next_setup_new", p, 3);

        // Card removal mid-PULSE
        fork
            ide_xfer(1'b0, 4'd3, 16'h0, rd, w, s, p, x);
            begin repeat (4) tick; detect_n = 1'b1; end
        join
        check("rm_data", rd, 16'hFFFF);
        check("rm_pulse", s, 2);
        check("rm_wait", w, 6);
        check("rm_power", power, 0);
        check("rm_irq", av_ctl_irq, 1);
        ide_xfer(1'b0, 4'd3, 16'h0, rd, w, s, p, x);
        check("absent_data", rd, 16'hFFFF);
        check("absent_wait", w, 0);
        check("absent_strobe", s, 0);
        ctl_read(2'd0, d);  check("rm_ctl0", d, 8'h0A);

        // Reset asserted during PULSE
        detect_n = 1'b0;
        repeat (DEB + 1) tick;
        check("reinsert_power", power, 1);
        tb_dat = 16'h7777;
        fork
            ide_xfer(1'b0, 4'd3, 16'h0, rd, w, s, p, x);
            begin
                repeat (4) tick;
                check("pre_rst_strobe", iord_n, 0);
                av_reset = 1'b1;
                #1;
                check("abort_iord_n", iord_n, 1);
                check("abort_waitreq", av_ide_waitrequest, 0);
                check("abort_cs_n", cs_n, 2'b11);
            end
        join
        check("abort_data", rd, 16'hFFFF);
        av_reset = 1'b0;
        tick;
        ctl_read(2'd2, d);  check("post_rst_timing", d, 8'h62);
        ctl_read(2'd0, d);  check("post_rst_ctl0", d, 8'h00);

        // IDE interrupt gating and card reset bit
        ctl_write(2'd1, 8'h01);
        ctl_write(2'd0, 8'h02);
        intrq = 1'b1;
        #1;
        check("ide_irq_absent", av_ide_irq, 0);
        repeat (DEB + 2) tick;
        check("ide_irq_on", av_ide_irq, 1);
        intrq = 1'b0;
        #1;
        check("ide_irq_off", av_ide_irq, 0);
        ctl_write(2'd0, 8'h06);
        check("reset_reg", reset_n_cf, 0);
        ctl_write(2'd0, 8'h02);
        check("reset_reg_off", reset_n_cf, 1);

        // iordy held low
        iordy = 1'b0; tb_dat = 16'hC0DE;
        ide_xfer(1'b0, 4'd5, 16'h0, rd, w, s, p, x);
`ifdef KERNEL_CF_IORDY_EN
        check("to_pulse", s, 1024);
        check("to_data", rd, 16'hFFFF);
        ctl_read(2'd3, d);  check("to_flag", d, 8'h01);
        ctl_write(2'd3, 8'h01);
        ctl_read(2'd3, d);  check("to_flag_clr", d, 8'h00);
`else
        check("noiordy_pulse", s, 6);
        check("noiordy_data", rd, 16'hC0DE);
        ctl_read(2'd3, d);  check("noiordy_flag", d, 8'h00);
`endif
        iordy = 1'b1;
        tb_drv = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/kernel_cf_pio.md
KERNEL_CF_PIO -- requirements
Module: kernel_cf_pio

Interface
REQ-001 Parameter DATA_WIDTH, default 16: IDE data bus width; legal values 8 and 16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: cycles detect_n must stay low before the card is reported present.
REQ-003 Parameter SETUP_DEF, default 2: reset value of the setup timing field, range 1..15.
REQ-004 Parameter PULSE_DEF, default 6: reset value of the pulse timing field, range 1..15.
REQ-005 Parameter TIMEOUT_CYCLES, default 1024: maximum iordy wait, in cycles.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 av_reset  in  1  reset; asynchronous, active-high.
REQ-008 av_ctl_address, av_ctl_chipselect_n, av_ctl_read_n, av_ctl_write_n  in  2/1/1/1  control slave.
REQ-009 av_ctl_writedata  in  8  control write data.
REQ-010 av_ctl_readdata  out  8  control read data, registered, valid 1 cycle after address.
REQ-011 av_ctl_irq  out  1  card insert/remove interrupt.
REQ-012 av_ide_address, av_ide_chipselect_n, av_ide_read_n, av_ide_write_n  in  4/1/1/1  IDE slave.
REQ-013 av_ide_writedata / av_ide_readdata  in / out  DATA_WIDTH  IDE slave data.
REQ-014 av_ide_waitrequest  out  1  high while a transfer is in progress.
REQ-015 av_ide_irq  out  1  intrq gated by ide_irq_en and card presence.
REQ-016 detect_n, intrq, iordy  in  1 each  card detect (low = inserted), device interrupt, device ready.
REQ-017 addr / cs_n  out  11 / 2  addr[2:0] = latched av_ide_address[2:0], addr[10:3] = 0; cs_n[0] low when address[3]=0, cs_n[1] low when address[3]=1.
REQ-018 iord_n, iowr_n  out  1 each  timed strobes, idle high.
REQ-019 data_cf  inout  DATA_WIDTH  driven only during write SETUP/PULSE with card present, otherwise high-Z.
REQ-020 power, reset_n_cf  out  1 each  power = power_reg AND present; reset_n_cf low when reset_reg, av_reset or not present.
REQ-021 atasel_n, we_n, rfu  out  1 each  constant 0, 1, 1.

Function
REQ-022 The control map SHALL be: 0 = {irq_en, reset_reg, power_reg, present} in bits 3:0 (present read-only); 1 = ide_irq_en in bit 0; 2 = {pulse[7:4], setup[3:0]}, a write of 0 to either field loading 1; 3 = timeout flag in bit 0, write-1-to-clear.
REQ-023 present SHALL set on the cycle its counter reaches DEBOUNCE_CYCLES with detect_n low; detect_n high SHALL clear present and the counter on the next edge.
REQ-024 av_ctl_irq SHALL set 1 cycle after any change of present while irq_en=1, and SHALL clear on a read of address 0; the clear takes priority over a simultaneous set.
REQ-025 The IDE FSM SHALL have states IDLE, SETUP, PULSE, RECOVER.
REQ-026 IDLE->SETUP on chipselect AND (read OR write) with present=1; address, direction and write data SHALL be latched on that edge.
REQ-027 SETUP SHALL last `setup` cycles with strobes high, then go to PULSE.
REQ-028 PULSE SHALL hold the selected strobe low for `pulse` cycles, then go to RECOVER.
REQ-029 For reads, data_cf SHALL be captured on the last PULSE edge.
REQ-030 RECOVER SHALL last 1 cycle with waitrequest low and readdata valid, then go to IDLE.
REQ-031 waitrequest SHALL be high from the accept cycle through the last PULSE cycle; a request with present=0 SHALL complete in 1 cycle with readdata all ones and no strobe.
REQ-032 Card removal during SETUP/PULSE SHALL deassert strobes next cycle, go to RECOVER and return all ones.
REQ-033 Timing register writes during a transfer SHALL take effect only on the next transfer.

Reset
REQ-034 av_reset SHALL force: FSM IDLE, strobes high, cs_n=11, data_cf high-Z, waitrequest 0, all control bits and irqs 0, present 0, setup=SETUP_DEF, pulse=PULSE_DEF, av_ctl_readdata 0.
REQ-035 Reset asserted mid-transfer SHALL abort immediately with no further strobe.

Configuration
REQ-036 With KERNEL_CF_IORDY_EN defined, PULSE SHALL extend past `pulse` cycles while iordy=0; after TIMEOUT_CYCLES total it SHALL end, set the timeout flag and return all ones. Without it, iordy is ignored and the timeout flag reads 0.

Verification
REQ-037 detect_n low 50000 cycles -> present=1 at cycle 50000, av_ctl_irq=1 if irq_en; read address 0 -> irq=0.
REQ-038 Defaults, read at address 3 -> cs_n=10, addr=3, iord_n low exactly 6 cycles after 2 setup cycles, readdata = data_cf captured, waitrequest low 1 cycle.
REQ-039 Write 0x00 to timing -> reads back 0x11; write 0x5A1B with timing 0x31 -> iowr_n low 3 cycles, data_cf=0x5A1B.
REQ-040 IORDY_EN: iordy held low -> strobe ends at 1024 cycles, timeout=1, readdata=0xFFFF; writing 1 to address 3 clears it.
REQ-041 Assert av_reset during PULSE -> strobes high and waitrequest 0 in the same cycle; detect_n high mid-transfer -> readdata 0xFFFF next RECOVER.
